// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file (NRD combinational reads, NWR writes) with a busy-bit scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                iss_v,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREGS-1:0]    busy_vec
);

  logic [AW-1:0]    ra_a    [NRD];
  logic [XLEN-1:0]  rd_a    [NRD];
  logic             rbusy_a [NRD];
  logic [AW-1:0]    wa_a    [NWR];
  logic [XLEN-1:0]  wd_a    [NWR];

  logic [XLEN-1:0]  regs_q  [NREGS];
  logic [XLEN-1:0]  regs_d  [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign ra_a[i]              = ra[i*AW +: AW];
    assign rd[i*XLEN +: XLEN]   = rd_a[i];
    assign rbusy[i]             = rbusy_a[i];
  end

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa_a[j] = wa[j*AW +: AW];
    assign wd_a[j] = wd[j*XLEN +: XLEN];
  end

  // Ascending port order lets the highest-indexed port win; issue is applied last so a new producer wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (wa_a[j] != '0)) begin
        regs_d[wa_a[j]] = wd_a[j];
        busy_d[wa_a[j]] = 1'b0;
      end
    end
    if (iss_v) begin
      busy_d[iss_rd] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_a[i]    = regs_q[ra_a[i]];
      rbusy_a[i] = busy_q[ra_a[i]];
`ifdef REGFILE_BYPASS_EN
      // Bypass is gated by rst_n so outputs stay zero throughout reset.
      for (int j = 0; j < NWR; j++) begin
        if (rst_n && we[j] && (wa_a[j] == ra_a[i])) begin
          rd_a[i]    = wd_a[j];
          rbusy_a[i] = iss_v && (iss_rd == ra_a[i]);
        end
      end
`endif
      if (ra_a[i] == '0) begin
        rd_a[i]    = '0;
        rbusy_a[i] = 1'b0;
      end
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: array-based reference model checked every cycle plus directed literal checks.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2*AW-1:0]   ra;
  logic [2*XLEN-1:0] rd;
  logic [1:0]        rbusy;
  logic [1:0]        we;
  logic [2*AW-1:0]   wa;
  logic [2*XLEN-1:0] wd;
  logic              iss_v;
  logic [AW-1:0]     iss_rd;
  logic [NREGS-1:0]  busy_vec;

  int tests = 0;
  int fails = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_busy [NREGS];

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_rd(iss_rd), .busy_vec(busy_vec)
  );

  always #10 clk = ~clk;

  // Reference model: registers and busy bits as plain arrays updated by the architectural rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (we[j] && wa[j*AW +: AW] != 0) begin
          m_regs[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
          m_busy[wa[j*AW +: AW]] = 1'b0;
        end
      end
      if (iss_v && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-low-phase after inputs have settled.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      begin
        logic [NREGS-1:0] exp_vec;
        for (int r = 0; r < NREGS; r++) exp_vec[r] = m_busy[r];
        check("busy_vec", 64'(busy_vec), 64'(exp_vec));
        for (int i = 0; i < 2; i++) begin
          logic [AW-1:0]   a;
          logic [XLEN-1:0] e;
          logic            eb;
          a  = ra[i*AW +: AW];
          e  = (a == 0) ? '0 : m_regs[a];
          eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
          for (int j = 0; j < 2; j++) begin
            if (rst_n && a != 0 && we[j] && wa[j*AW +: AW] == a) begin
              e  = wd[j*XLEN +: XLEN];
              eb = iss_v && (iss_rd == a);
            end
          end
`endif
          check($sformatf("model rd[%0d]", i), 64'(rd[i*XLEN +: XLEN]), 64'(e));
          check($sformatf("model rbusy[%0d]", i), 64'(rbusy[i]), 64'(eb));
        end
      end
    end
  end

  task automatic drive(input logic [1:0] w, input int a0, input int a1, input logic [31:0] d0,
                       input logic [31:0] d1, input logic iv, input int ir, input int r0, input int r1);
    @(negedge clk);
    we     = w;
    wa     = {AW'(a1), AW'(a0)};
    wd     = {d1, d0};
    iss_v  = iv;
    iss_rd = AW'(ir);
    ra     = {AW'(r1), AW'(r0)};
    #4;
  endtask

  task automatic idle(input int r0, input int r1);
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, r0, r1);
  endtask

  initial begin
    rst_n = 1'b0; we = '0; wa = '0; wd = '0; iss_v = 1'b0; iss_rd = '0; ra = '0;
    repeat (2) @(negedge clk);
    #1 check("reset rd", 64'(rd), 64'd0);
    check("reset busy_vec", 64'(busy_vec), 64'd0);
    rst_n = 1'b1;

    for (int a = 0; a < NREGS; a++) begin
      idle(a, NREGS-1-a);
      check("post-reset rd", 64'(rd), 64'd0);
      check("post-reset rbusy", 64'(rbusy), 64'd0);
    end

    drive(2'b01, 5, 0, 32'hDEADBEEF, 0, 1'b0, 0, 5, 0);
    drive(2'b01, 0, 0, 32'h1234, 0, 1'b0, 0, 5, 0);
    check("write reg5", 64'(rd[31:0]), 64'hDEADBEEF);
    idle(0, 5);
    check("reg0 reads zero", 64'(rd[31:0]), 64'd0);
    check("reg5 port1", 64'(rd[63:32]), 64'hDEADBEEF);

    drive(2'b11, 7, 7, 32'h11, 32'h22, 1'b0, 0, 0, 0);
    idle(7, 0);
    check("same-addr write high port wins", 64'(rd[31:0]), 64'h22);

    drive(2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 0);
    check("busy before edge", 64'(busy_vec[9]), 64'd0);
    idle(9, 0);
    check("busy set", 64'(busy_vec[9]), 64'd1);
    check("rbusy set", 64'(rbusy[0]), 64'd1);
    drive(2'b10, 0, 9, 0, 32'h99, 1'b1, 9, 9, 0);
    idle(9, 0);
    check("issue+wb keeps busy", 64'(busy_vec[9]), 64'd1);
    check("wb data with issue", 64'(rd[31:0]), 64'h99);
    drive(2'b10, 0, 9, 0, 32'h77, 1'b0, 0, 9, 0);
    idle(9, 0);
    check("wb clears busy", 64'(busy_vec[9]), 64'd0);
    check("wb data", 64'(rd[31:0]), 64'h77);

    drive(2'b11, 0, 0, 32'hFFFF, 32'hEEEE, 1'b1, 0, 0, 0);
    idle(0, 0);
    check("reg0 issue/write ignored", 64'(busy_vec), 64'd0);

    drive(2'b01, 3, 0, 32'hA5A5A5A5, 0, 1'b0, 0, 0, 3);
`ifdef REGFILE_BYPASS_EN
    check("bypass rd[1]", 64'(rd[63:32]), 64'hA5A5A5A5);
`else
    check("no-bypass rd[1]", 64'(rd[63:32]), 64'd0);
`endif
    idle(0, 3);
    check("reg3 after write", 64'(rd[63:32]), 64'hA5A5A5A5);

    drive(2'b01, 4, 0, 32'h55, 0, 1'b1, 4, 4, 0);
    idle(4, 0);
    check("reg4 written", 64'(rd[31:0]), 64'h55);
    check("reg4 busy", 64'(busy_vec[4]), 64'd1);
    #1 rst_n = 1'b0;
    #1 check("async reset rd", 64'(rd[31:0]), 64'd0);
    check("async reset busy_vec", 64'(busy_vec), 64'd0);
    drive(2'b01, 4, 0, 32'h66, 0, 1'b1, 4, 5, 4);
    @(negedge clk);
    #1 check("held in reset rd", 64'(rd), 64'd0);
    check("held in reset busy", 64'(busy_vec), 64'd0);
    rst_n = 1'b1;
    #3 check("no update before first edge", 64'(busy_vec), 64'd0);
    idle(4, 0);
    check("first edge after reset writes", 64'(rd[31:0]), 64'h66);
    check("first edge after reset issues", 64'(busy_vec[4]), 64'd1);

    for (int k = 0; k < 200; k++) begin
      drive(2'($urandom_range(0, 3)), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31));
    end
    idle(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
